// File: rtl/copro_issue_maindec.sv
// Main decoder with a multi-cycle coprocessor issue FSM (IDLE/ISSUE/WAIT/WB).
// Define COPRO_PERF_CNT_EN to add the perf_stall_cycles / perf_issues counters.
module copro_issue_maindec #(
    parameter int                   NUM_COPRO = 2,
    parameter logic [NUM_COPRO-1:0] SRCA_MASK = 2'b10,
    parameter int                   TIMEOUT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_valid,
    input  logic [6:0]           op,
    input  logic [NUM_COPRO-1:0] copro_done,
    output logic [NUM_COPRO-1:0] copro_start,
    output logic                 stall,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 Branch,
    output logic                 Jump,
    output logic                 PCRControl,
    output logic                 ALU3SrcA,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           ALU3SrcB,
    output logic [1:0]           ResultSrc,
    output logic [2:0]           ALUOp,
    output logic                 illegal,
    output logic                 timeout
`ifdef COPRO_PERF_CNT_EN
    ,
    output logic [31:0]          perf_stall_cycles,
    output logic [15:0]          perf_issues
`endif
);

    localparam int                   CH_W     = (NUM_COPRO > 1) ? $clog2(NUM_COPRO) : 1;
    localparam logic [6:0]           NUM_OP   = 7'(NUM_COPRO);
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       pcr;
        logic       srca;
        logic [1:0] imm_src;
        logic [1:0] srcb;
        logic [1:0] result_src;
        logic [2:0] alu_op;
        logic       illegal;
    } ctl_t;

    state_t                 state, state_n;
    logic [CH_W-1:0]        ch, ch_n;
    logic [TIMEOUT_W-1:0]   cnt, cnt_n;
    logic                   timeout_n;
    ctl_t                   ctl;
    logic                   stall_c;
    logic [NUM_COPRO-1:0]   start_c;

    function automatic ctl_t decode(input logic [6:0] o);
        ctl_t c;
        c = '0;
        unique case (o)
            OP_LW:   begin c.reg_write = 1'b1; c.srcb = 2'b01; c.result_src = 2'b01; end
            OP_SW:   begin c.mem_write = 1'b1; c.imm_src = 2'b01; c.srcb = 2'b01; end
            OP_R:    begin c.reg_write = 1'b1; c.alu_op = 3'b010; end
            OP_BR:   begin c.branch = 1'b1; c.imm_src = 2'b10; c.alu_op = 3'b001; end
            OP_IALU: begin c.reg_write = 1'b1; c.srcb = 2'b01; c.alu_op = 3'b010; end
            OP_JAL:  begin c.reg_write = 1'b1; c.imm_src = 2'b11; c.result_src = 2'b10; c.jump = 1'b1; end
            OP_JALR: begin
                c.reg_write  = 1'b1;
                c.srcb       = 2'b01;
                c.result_src = 2'b10;
                c.jump       = 1'b1;
                c.pcr        = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_n   = state;
        ch_n      = ch;
        cnt_n     = cnt;
        timeout_n = timeout;
        ctl       = '0;
        stall_c   = 1'b0;
        start_c   = '0;
        unique case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    if (op < NUM_OP) begin
                        stall_c = 1'b1;
                        ch_n    = op[CH_W-1:0];
                        state_n = S_ISSUE;
                    end else begin
                        ctl = decode(op);
                    end
                end
            end
            S_ISSUE: begin
                stall_c = 1'b1;
                start_c = NUM_COPRO'(1) << ch;
                cnt_n   = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                stall_c = 1'b1;
                if (copro_done[ch]) begin
                    state_n = S_WB;
                end else if (cnt == CNT_LAST) begin
                    // This is the last permitted wait cycle: give up, retire as NOP.
                    timeout_n = 1'b1;
                    state_n   = S_IDLE;
                end else begin
                    cnt_n = cnt + TIMEOUT_W'(1);
                end
            end
            S_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.result_src = 2'b11;
                ctl.srcb       = 2'b10;
                ctl.alu_op     = 3'b110;
                ctl.srca       = SRCA_MASK[ch];
                state_n        = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            ch      <= '0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all update together at the edge.
            state   <= state_n;
            ch      <= ch_n;
            cnt     <= cnt_n;
            timeout <= timeout_n;
        end
    end

    // Outputs are forced low while reset is held, independent of the clock.
    assign copro_start = reset ? start_c : '0;
    assign stall       = reset & stall_c;
    assign RegWrite    = reset & ctl.reg_write;
    assign MemWrite    = reset & ctl.mem_write;
    assign Branch      = reset & ctl.branch;
    assign Jump        = reset & ctl.jump;
    assign PCRControl  = reset & ctl.pcr;
    assign ALU3SrcA    = reset & ctl.srca;
    assign ImmSrc      = reset ? ctl.imm_src    : 2'b00;
    assign ALU3SrcB    = reset ? ctl.srcb       : 2'b00;
    assign ResultSrc   = reset ? ctl.result_src : 2'b00;
    assign ALUOp       = reset ? ctl.alu_op     : 3'b000;
    assign illegal     = reset & ctl.illegal;

`ifdef COPRO_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_issues       <= '0;
        end else begin
            if (stall && (perf_stall_cycles != 32'hFFFF_FFFF))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (state == S_IDLE && state_n == S_ISSUE)
                perf_issues <= perf_issues + 16'd1;
        end
    end
`endif

endmodule
